// File: rtl/axis_peak_select.sv
// axis_peak_select: scans one s_axis beat of NUM_CHANNELS magnitudes and emits the strongest channel (data, abs, index, peak flag) on m_axis
module axis_peak_select #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHANNEL_WIDTH = 32,
  localparam int ABS_WIDTH = (CHANNEL_WIDTH <= 32) ? 16 : 32,
  localparam int INDEX_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int DATA_WIDTH = CHANNEL_WIDTH * NUM_CHANNELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_abs,
  input  logic [ABS_WIDTH-1:0]     threshold,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [CHANNEL_WIDTH-1:0] m_axis_tdata,
  output logic [ABS_WIDTH-1:0]     m_axis_tdata_abs,
  output logic [INDEX_WIDTH-1:0]   m_axis_tindex,
  output logic                     m_axis_tpeak
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_CHANNELS - 1);
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ABS_WIDTH-1:0] abs_q [NUM_CHANNELS];
  logic [ABS_WIDTH-1:0] thr_q, max_q, cur_abs, nxt_max;
  logic [INDEX_WIDTH-1:0] cnt, best, nxt_best;
  logic gt, last;
  logic unused_abs_hi;
  assign unused_abs_hi = ^s_axis_tdata_abs;
  assign s_axis_tready = (state == IDLE) & ~rst;
  always_comb begin
    cur_abs = abs_q[cnt];
    gt = cur_abs > max_q;
    nxt_max = gt ? cur_abs : max_q;
    nxt_best = gt ? cnt : best;
    last = cnt == LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tdata_abs <= '0;
      m_axis_tindex <= '0;
      m_axis_tpeak <= 1'b0;
      max_q <= '0;
      best <= '0;
      cnt <= '0;
    end else if (state == IDLE && s_axis_tvalid) begin
      data_q <= s_axis_tdata;
      for (int n = 0; n < NUM_CHANNELS; n++) abs_q[n] <= s_axis_tdata_abs[n*CHANNEL_WIDTH +: ABS_WIDTH];
      thr_q <= threshold;
      max_q <= '0;
      best <= '0;
      cnt <= '0;
      state <= SCAN;
    end else if (state == SCAN) begin
      max_q <= nxt_max;
      best <= nxt_best;
      if (last) begin
        m_axis_tdata <= data_q[nxt_best*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        m_axis_tdata_abs <= nxt_max;
        m_axis_tindex <= nxt_best;
        m_axis_tpeak <= nxt_max >= thr_q;
        m_axis_tvalid <= 1'b1;
        state <= HOLD;
      end else
        cnt <= cnt + 1'b1;
    end else if (state == HOLD && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_axis_peak_select.sv
// tb_axis_peak_select: randomized and directed checks of axis_peak_select against an argmax reference model
module tb_axis_peak_select;
  typedef struct {
    logic [127:0] d;
    logic [15:0] a [4];
    logic [15:0] t;
  } frame_t;
  typedef struct {
    int idx;
    logic [15:0] abs;
    logic [31:0] data;
    logic peak;
  } res_t;
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 1;
  logic s_ready, m_valid, m_peak;
  logic [127:0] s_data = '0, s_abs = '0;
  logic [15:0] thr = '0, m_abs;
  logic [31:0] m_data;
  logic [1:0] m_idx;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  axis_peak_select dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tdata(s_data), .s_axis_tdata_abs(s_abs), .threshold(thr),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tdata_abs(m_abs),
    .m_axis_tindex(m_idx), .m_axis_tpeak(m_peak)
  );
  function automatic res_t model(input frame_t f);
    res_t r;
    logic [127:0] d;
    int b = 0;
    for (int i = 1; i < 4; i++) if (f.a[i] > f.a[b]) b = i;
    d = f.d;
    r.idx = b;
    r.abs = f.a[b];
    r.data = d[b*32 +: 32];
    r.peak = f.a[b] >= f.t;
    return r;
  endfunction
  function automatic frame_t rand_frame(input int maxv);
    frame_t f;
    f.d = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) f.a[i] = 16'($urandom_range(0, maxv));
    f.t = 16'($urandom_range(0, maxv));
    return f;
  endfunction
  function automatic frame_t make_frame(input int a0, input int a1, input int a2, input int a3, input int t);
    frame_t f;
    f = rand_frame(0);
    f.a[0] = 16'(a0); f.a[1] = 16'(a1); f.a[2] = 16'(a2); f.a[3] = 16'(a3);
    f.t = 16'(t);
    return f;
  endfunction
  task automatic drive(input frame_t f);
    logic [127:0] a = '0;
    for (int i = 0; i < 4; i++) a[i*32 +: 16] = f.a[i];
    s_data = f.d;
    s_abs = a;
    thr = f.t;
  endtask
  task automatic accept_beat(input frame_t f, output bit ok);
    drive(f);
    s_valid = 1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) if (s_ready) ok = 1; else @(negedge clk);
    @(posedge clk);
    #1;
    s_valid = 0;
    drive(rand_frame(65535));
  endtask
  task automatic wait_result(output bit got, output int edges, output res_t r);
    got = 0;
    edges = 0;
    while (!got && edges < 30) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        got = 1;
        r.idx = int'(m_idx); r.abs = m_abs; r.data = m_data; r.peak = m_peak;
      end
      @(posedge clk);
      edges++;
      #1;
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b want=0", s_ready); end
    checks++;
    if ({m_valid, m_idx, m_abs, m_data, m_peak} !== '0) begin
      failures++; $display("FAIL reset_outputs got valid=%b idx=%0d abs=%0d data=%h peak=%b want all 0", m_valid, m_idx, m_abs, m_data, m_peak);
    end
    rst = 0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_tready got=%b want=1", s_ready); end
  endtask
  task automatic test_directed;
    frame_t tbl [3];
    frame_t f;
    res_t e, r;
    bit ok, got;
    int edges;
    tbl[0] = make_frame(10, 300, 25, 299, 200);
    tbl[1] = make_frame(50, 80, 80, 12, 81);
    tbl[2] = make_frame(0, 0, 0, 0, 0);
    m_ready = 1;
    for (int k = 0; k < 3; k++) begin
      f = tbl[k];
      e = model(f);
      accept_beat(f, ok);
      wait_result(got, edges, r);
      checks++;
      if (!ok || !got || edges != 5) begin
        failures++; $display("FAIL directed%0d_timing accepted=%b result=%b edges=%0d want edges=5", k, ok, got, edges);
      end
      checks++;
      if (r !== e) begin
        failures++; $display("FAIL directed%0d_result got idx=%0d abs=%0d data=%h peak=%b want idx=%0d abs=%0d data=%h peak=%b", k, r.idx, r.abs, r.data, r.peak, e.idx, e.abs, e.data, e.peak);
      end
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        failures++; $display("FAIL directed%0d_release got valid=%b tready=%b want 0/1", k, m_valid, s_ready);
      end
    end
  endtask
  task automatic test_backpressure;
    frame_t f;
    res_t e, r;
    bit ok, seen = 0;
    int bad = 0;
    f = rand_frame(65535);
    e = model(f);
    m_ready = 0;
    accept_beat(f, ok);
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = m_valid; end
    r.idx = int'(m_idx); r.abs = m_abs; r.data = m_data; r.peak = m_peak;
    checks++;
    if (!ok || !seen || r !== e) begin
      failures++; $display("FAIL bp_result got idx=%0d abs=%0d data=%h peak=%b seen=%b want idx=%0d abs=%0d data=%h peak=%b", r.idx, r.abs, r.data, r.peak, seen, e.idx, e.abs, e.data, e.peak);
    end
    for (int i = 0; i < 10; i++) begin
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || {m_idx, m_abs, m_data, m_peak} !== {2'(e.idx), e.abs, e.data, e.peak}) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_stable unstable_cycles=%0d want 0", bad); end
    m_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b tready=%b want 0/1", m_valid, s_ready);
    end
  endtask
  task automatic test_reset_mid;
    frame_t f;
    res_t e, r;
    bit ok, got, beat = 0;
    int edges;
    m_ready = 1;
    accept_beat(rand_frame(65535), ok);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL midrst_tready got=%b want=0", s_ready); end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_valid) beat = 1; end
    checks++;
    if (beat) begin failures++; $display("FAIL midrst_no_beat got beat=1 want 0"); end
    f = make_frame(7, 3, 9, 1, $urandom_range(0, 20));
    e = model(f);
    accept_beat(f, ok);
    wait_result(got, edges, r);
    checks++;
    if (!ok || !got || r !== e) begin
      failures++; $display("FAIL midrst_next got idx=%0d abs=%0d peak=%b ok=%b got=%b want idx=%0d abs=%0d peak=%b", r.idx, r.abs, r.peak, ok, got, e.idx, e.abs, e.peak);
    end
  endtask
  task automatic test_random;
    frame_t f;
    res_t e, r;
    bit ok, got;
    int bad = 0;
    int edges;
    m_ready = 1;
    for (int k = 0; k < 30; k++) begin
      f = rand_frame(k < 15 ? 7 : 65535);
      e = model(f);
      accept_beat(f, ok);
      wait_result(got, edges, r);
      checks++;
      if (!ok || !got || r !== e) begin
        bad++; failures++;
        $display("FAIL random%0d got idx=%0d abs=%0d data=%h peak=%b want idx=%0d abs=%0d data=%h peak=%b", k, r.idx, r.abs, r.data, r.peak, e.idx, e.abs, e.data, e.peak);
      end
    end
  endtask
  task automatic test_back_to_back;
    frame_t f;
    res_t q [$];
    res_t e, r;
    bit acc, hs;
    int cyc = 0, last_acc = -1, results = 0;
    m_ready = 1;
    f = rand_frame(15);
    drive(f);
    s_valid = 1;
    while (results < 5 && cyc < 200) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      hs = m_valid && m_ready;
      if (hs) begin r.idx = int'(m_idx); r.abs = m_abs; r.data = m_data; r.peak = m_peak; end
      @(posedge clk);
      cyc++;
      #1;
      if (acc) begin
        q.push_back(model(f));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin failures++; $display("FAIL b2b_spacing got=%0d want=6", cyc - last_acc); end
        end
        last_acc = cyc;
        f = rand_frame(15);
        drive(f);
      end
      if (hs) begin
        results++;
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_order got unexpected beat idx=%0d want none", r.idx);
        end else begin
          e = q.pop_front();
          if (r !== e) begin
            failures++; $display("FAIL b2b_result got idx=%0d abs=%0d data=%h peak=%b want idx=%0d abs=%0d data=%h peak=%b", r.idx, r.abs, r.data, r.peak, e.idx, e.abs, e.data, e.peak);
          end
        end
      end
    end
    s_valid = 0;
    checks++;
    if (results < 5) begin failures++; $display("FAIL b2b_timeout got results=%0d want 5", results); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
